// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward sequencer for the 5-stage core: load-use interlock,
// multi-cycle multiply hold in EX, taken-branch flush, EX operand forwarding.
//
// state    | meaning
// RUN      | normal issue; hazard and branch logic active
// MUL_WAIT | multiply occupying EX; front of pipe held until the last cycle
module pipeline_hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int REG_W      = 5,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_wr_en,
    input  logic             ex_is_load,
    input  logic             ex_is_mul,
    input  logic             ex_branch_taken,
    input  logic [REG_W-1:0] mem_rd,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             mem_wr_en,
    input  logic             wb_wr_en,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             bubble_ex,
    output logic             bubble_mem,
    output logic             flush_id,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mul_start,
    output logic             mul_done,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int MC_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;

    typedef enum logic {RUN, MUL_WAIT} state_t;

    state_t          state, state_nxt;
    logic [MC_W-1:0] mul_cnt, mul_cnt_nxt;
    logic            load_use;

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
        if (mem_wr_en && mem_rd != '0 && mem_rd == src)
            return 2'b01;
        else if (wb_wr_en && wb_rd != '0 && wb_rd == src)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign load_use = ex_is_load && ex_wr_en && (ex_rd != '0) &&
                      ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            mul_cnt <= '0;
        end else begin
            state   <= state_nxt;
            mul_cnt <= mul_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        mul_cnt_nxt = mul_cnt;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        bubble_ex   = 1'b0;
        bubble_mem  = 1'b0;
        flush_id    = 1'b0;
        mul_start   = 1'b0;
        mul_done    = 1'b0;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        // Everything is forced quiet while reset is held, forwarding included.
        if (!rst) begin
            fwd_a = fwd_sel(ex_rs);
            fwd_b = fwd_sel(ex_rt);
            case (state)
                RUN: begin
                    if (ex_branch_taken) begin
                        flush_id  = 1'b1;
                        bubble_ex = 1'b1;
                    end else if (ex_is_mul) begin
                        mul_start   = 1'b1;
                        stall_if    = 1'b1;
                        stall_id    = 1'b1;
                        stall_ex    = 1'b1;
                        bubble_mem  = 1'b1;
                        mul_cnt_nxt = MC_W'(MUL_CYCLES - 2);
                        state_nxt   = MUL_WAIT;
                    end else if (load_use) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        bubble_ex = 1'b1;
                    end
                end
                MUL_WAIT: begin
                    if (mul_cnt != '0) begin
                        stall_if    = 1'b1;
                        stall_id    = 1'b1;
                        stall_ex    = 1'b1;
                        bubble_mem  = 1'b1;
                        mul_cnt_nxt = mul_cnt - MC_W'(1);
                    end else begin
                        mul_done  = 1'b1;
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (stall_if && stall_cycles != '1)
            stall_cycles <= stall_cycles + CNT_W'(1);
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed cases then random traffic,
// expected responses from a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int RW = 5;
    localparam int MULC = 4;

    typedef struct packed {
        logic          rst;
        logic [RW-1:0] id_rs, id_rt;
        logic          id_uses_rs, id_uses_rt;
        logic [RW-1:0] ex_rs, ex_rt, ex_rd;
        logic          ex_wr_en, ex_is_load, ex_is_mul, ex_branch_taken;
        logic [RW-1:0] mem_rd, wb_rd;
        logic          mem_wr_en, wb_wr_en;
    } stim_t;

    typedef struct packed {
        logic        stall_if, stall_id, stall_ex, bubble_ex, bubble_mem, flush_id;
        logic [1:0]  fwd_a, fwd_b;
        logic        mul_start, mul_done;
        logic [31:0] sc32;
        logic [3:0]  sc4;
    } resp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [RW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic          id_uses_rs, id_uses_rt, ex_wr_en, ex_is_load, ex_is_mul;
    logic          ex_branch_taken, mem_wr_en, wb_wr_en;

    logic        stall_if, stall_id, stall_ex, bubble_ex, bubble_mem, flush_id;
    logic [1:0]  fwd_a, fwd_b;
    logic        mul_start, mul_done;
    logic [31:0] stall_cycles;

    logic        s4_if, s4_id, s4_ex, b4_ex, b4_mem, f4_id, m4_start, m4_done;
    logic [1:0]  f4_a, f4_b;
    logic [3:0]  stall_cycles4;

    pipeline_hazard_ctrl #(.MUL_CYCLES(MULC), .REG_W(RW), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en),
        .ex_is_load(ex_is_load), .ex_is_mul(ex_is_mul), .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_wr_en(mem_wr_en), .wb_wr_en(wb_wr_en),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .bubble_ex(bubble_ex), .bubble_mem(bubble_mem), .flush_id(flush_id),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mul_start(mul_start), .mul_done(mul_done),
        .stall_cycles(stall_cycles)
    );

    pipeline_hazard_ctrl #(.MUL_CYCLES(MULC), .REG_W(RW), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en),
        .ex_is_load(ex_is_load), .ex_is_mul(ex_is_mul), .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_wr_en(mem_wr_en), .wb_wr_en(wb_wr_en),
        .stall_if(s4_if), .stall_id(s4_id), .stall_ex(s4_ex),
        .bubble_ex(b4_ex), .bubble_mem(b4_mem), .flush_id(f4_id),
        .fwd_a(f4_a), .fwd_b(f4_b), .mul_start(m4_start), .mul_done(m4_done),
        .stall_cycles(stall_cycles4)
    );

    resp_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    bit    drive_done = 1'b0;

    // Reference model state: EX cycles still owed to the running multiply,
    // and stall totals as seen through a 32-bit and a 4-bit saturating counter.
    int     mul_left = 0;
    longint cnt32 = 0;
    int     cnt4 = 0;

    function automatic logic [1:0] fwd_ref(input stim_t s, input logic [RW-1:0] src);
        if (src == 0) return 2'b00;
        if (s.mem_wr_en && s.mem_rd == src) return 2'b01;
        if (s.wb_wr_en && s.wb_rd == src) return 2'b10;
        return 2'b00;
    endfunction

    function automatic resp_t model_step(input stim_t s);
        resp_t e;
        bit    hazard;
        e = '0;
        e.sc32 = cnt32[31:0];
        e.sc4  = cnt4[3:0];
        if (s.rst) begin
            mul_left = 0;
            cnt32 = 0;
            cnt4 = 0;
            return e;
        end
        e.fwd_a = fwd_ref(s, s.ex_rs);
        e.fwd_b = fwd_ref(s, s.ex_rt);
        hazard = s.ex_is_load && s.ex_wr_en && s.ex_rd != 0 &&
                 ((s.id_uses_rs && s.id_rs == s.ex_rd) || (s.id_uses_rt && s.id_rt == s.ex_rd));
        if (mul_left == 0) begin
            if (s.ex_branch_taken) begin
                e.flush_id = 1; e.bubble_ex = 1;
            end else if (s.ex_is_mul) begin
                e.mul_start = 1; e.stall_if = 1; e.stall_id = 1; e.stall_ex = 1; e.bubble_mem = 1;
                mul_left = MULC - 1;
            end else if (hazard) begin
                e.stall_if = 1; e.stall_id = 1; e.bubble_ex = 1;
            end
        end else if (mul_left == 1) begin
            e.mul_done = 1;
            mul_left = 0;
        end else begin
            e.stall_if = 1; e.stall_id = 1; e.stall_ex = 1; e.bubble_mem = 1;
            mul_left--;
        end
        if (e.stall_if) begin
            if (cnt32 < 64'hFFFF_FFFF) cnt32++;
            if (cnt4 < 15) cnt4++;
        end
        return e;
    endfunction

    task automatic apply(input stim_t s);
        resp_t e;
        @(negedge clk);
        rst = s.rst; id_rs = s.id_rs; id_rt = s.id_rt;
        id_uses_rs = s.id_uses_rs; id_uses_rt = s.id_uses_rt;
        ex_rs = s.ex_rs; ex_rt = s.ex_rt; ex_rd = s.ex_rd; ex_wr_en = s.ex_wr_en;
        ex_is_load = s.ex_is_load; ex_is_mul = s.ex_is_mul; ex_branch_taken = s.ex_branch_taken;
        mem_rd = s.mem_rd; wb_rd = s.wb_rd; mem_wr_en = s.mem_wr_en; wb_wr_en = s.wb_wr_en;
        e = model_step(s);
        #1;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s vector %0d: got %0h expected %0h", name, n_vec, act, expv);
        end
    endtask

    // Monitor: one response per cycle, checked mid-cycle after inputs settle.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_vec++;
                chk("stall_if",   32'(stall_if),   32'(e.stall_if));
                chk("stall_id",   32'(stall_id),   32'(e.stall_id));
                chk("stall_ex",   32'(stall_ex),   32'(e.stall_ex));
                chk("bubble_ex",  32'(bubble_ex),  32'(e.bubble_ex));
                chk("bubble_mem", 32'(bubble_mem), 32'(e.bubble_mem));
                chk("flush_id",   32'(flush_id),   32'(e.flush_id));
                chk("fwd_a",      32'(fwd_a),      32'(e.fwd_a));
                chk("fwd_b",      32'(fwd_b),      32'(e.fwd_b));
                chk("mul_start",  32'(mul_start),  32'(e.mul_start));
                chk("mul_done",   32'(mul_done),   32'(e.mul_done));
                chk("stall_cycles",   stall_cycles,         e.sc32);
                chk("stall_cycles_4", 32'(stall_cycles4),   32'(e.sc4));
                chk("stall_if_4",     32'(s4_if),           32'(e.stall_if));
            end
        end
    end

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t load_use_stim();
        stim_t s;
        s = '0;
        s.ex_is_load = 1; s.ex_wr_en = 1; s.ex_rd = 5; s.id_rs = 5; s.id_uses_rs = 1;
        return s;
    endfunction

    initial begin
        stim_t s;
        rst = 1'b1;
        {id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd} = '0;
        {id_uses_rs, id_uses_rt, ex_wr_en, ex_is_load, ex_is_mul} = '0;
        {ex_branch_taken, mem_wr_en, wb_wr_en} = '0;
        repeat (2) @(posedge clk);

        s = load_use_stim(); s.rst = 1; s.mem_rd = 3; s.mem_wr_en = 1; s.ex_rs = 3;
        apply(s);                                 // outputs quiet under reset
        apply(idle());

        apply(load_use_stim());
        s = load_use_stim(); s.ex_rd = 0; s.id_rs = 0; apply(s);
        s = load_use_stim(); s.id_uses_rs = 0; apply(s);
        s = load_use_stim(); s.id_uses_rs = 0; s.id_rt = 5; s.id_uses_rt = 1; apply(s);

        s = idle(); s.mem_rd = 3; s.mem_wr_en = 1; s.wb_rd = 3; s.wb_wr_en = 1;
        s.ex_rs = 3; s.ex_rt = 3; apply(s);
        s.mem_wr_en = 0; apply(s);
        s.ex_rs = 0; apply(s);
        s.ex_rt = 0; s.wb_rd = 0; apply(s);

        s = idle(); s.rst = 1; apply(s);
        s = idle(); s.ex_is_mul = 1; apply(s);
        s = idle(); s.ex_is_mul = 1; repeat (3) apply(s);
        repeat (2) apply(idle());

        s = load_use_stim(); s.ex_branch_taken = 1; s.ex_is_mul = 1; apply(s);
        s = load_use_stim(); s.ex_branch_taken = 1; apply(s);

        s = idle(); s.rst = 1; apply(s);
        s = idle(); s.ex_is_mul = 1; apply(s);
        apply(idle());
        s = idle(); s.rst = 1; apply(s);
        repeat (4) apply(idle());

        s = idle(); s.rst = 1; apply(s);
        repeat (20) apply(load_use_stim());
        repeat (2) apply(idle());

        for (int i = 0; i < 3000; i++) begin
            s = '0;
            s.rst             = ($urandom_range(0, 99) < 2);
            s.id_rs           = RW'($urandom_range(0, 3));
            s.id_rt           = RW'($urandom_range(0, 3));
            s.id_uses_rs      = $urandom_range(0, 1) == 1;
            s.id_uses_rt      = $urandom_range(0, 1) == 1;
            s.ex_rs           = RW'($urandom_range(0, 3));
            s.ex_rt           = RW'($urandom_range(0, 3));
            s.ex_rd           = RW'($urandom_range(0, 3));
            s.ex_wr_en        = $urandom_range(0, 3) != 0;
            s.ex_is_load      = $urandom_range(0, 1) == 1;
            s.ex_is_mul       = $urandom_range(0, 7) == 0;
            s.ex_branch_taken = $urandom_range(0, 7) == 0;
            s.mem_rd          = RW'($urandom_range(0, 3));
            s.wb_rd           = RW'($urandom_range(0, 3));
            s.mem_wr_en       = $urandom_range(0, 1) == 1;
            s.wb_wr_en        = $urandom_range(0, 1) == 1;
            apply(s);
        end

        drive_done = 1'b1;
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d responses left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
